seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Clocked, parametrised successor to the 4-bit combinational ALU, with a valid/ready handshake on both input and output.
- Operand width is generalised to WIDTH; carry and signed-overflow flags are separated; adds SHL, SHR and an iterative multi-cycle unsigned MUL.
- Sits between the control FSM (operand/opcode producer) and the writeback stage; exactly one result register, no internal queue.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- CNTW, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; for shifts, B[$clog2(WIDTH)-1:0] is the shift amount.
- opcode  input  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 AND, 101 OR, 110 XOR, 111 MUL.
- inValid  input  1  A/B/opcode valid.
- inReady  output  1  block can accept this cycle.
- result  output  WIDTH  registered result.
- zeroFlag  output  1  result == 0.
- carryFlag  output  1  carry/borrow/shifted-out bit.
- overflowFlag  output  1  signed overflow (ADD/SUB) or truncation (MUL).
- outValid  output  1  result and flags valid.
- outReady  input  1  consumer accepts the result.

Behaviour:
- Reset (async, while rst_n=0):
  - State IDLE; outValid=0.
  - result, zeroFlag, carryFlag and overflowFlag all 0.
  - inReady reflects IDLE with an empty output, i.e. 1.
  - Reset mid-MUL discards the operation; nothing is emitted afterwards.
- States: IDLE, MUL_BUSY.
- inReady = (state==IDLE) && (!outValid || outReady). Accept = inValid && inReady.
- Single-cycle ops (000-110): accepted at edge k; result and flags load and outValid=1 after edge k.
  - Back-to-back throughput is 1 per cycle while outReady=1.
- ADD:
  - result = (A+B) mod 2^WIDTH.
  - carryFlag = bit WIDTH of the sum.
  - overflowFlag = (A[MSB]==B[MSB]) && (result[MSB]!=A[MSB]).
- SUB:
  - result = (A-B) mod 2^WIDTH.
  - carryFlag = borrow (A<B unsigned).
  - overflowFlag = (A[MSB]!=B[MSB]) && (result[MSB]!=A[MSB]).
- SHL/SHR: logical shift by amount n.
  - carryFlag = last bit shifted out; 0 when n=0.
  - overflowFlag = 0.
- AND/OR/XOR: carryFlag = overflowFlag = 0.
- MUL: unsigned, shift-and-add, one bit of B per cycle.
  - Accept edge k: latch operands, clear the 2*WIDTH accumulator and counter; IDLE->MUL_BUSY.
  - Edges k+1..k+WIDTH: one iteration each.
  - At edge k+WIDTH: result = product[WIDTH-1:0]; overflowFlag = |product[2*WIDTH-1:WIDTH]; carryFlag = 0; outValid=1; ->IDLE.
  - Latency is WIDTH cycles; inReady=0 throughout MUL_BUSY.
- zeroFlag is always computed from the value written into result.
- Output hold: while outValid && !outReady, result and all flags are frozen and inReady=0.
- Output drain: outValid && outReady with no new accept -> outValid=0 next edge; result and flags keep their last values.
- Simultaneous drain and accept in the same cycle: new result replaces the old one; outValid stays 1.
- A MUL may not start while the output is occupied and unaccepted; inReady already enforces this.
- Input changes while inReady=0 are ignored; the producer holds inValid.

Decomposition:
- alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - state encoding ST_IDLE and ST_MUL_BUSY;
  - a flag-bundle typedef {zero, carry, overflow}.
- One natural sub-module, alu_shift_add_mul:
  - start/done handshake, WIDTH-parametrised;
  - owns the accumulator and counter;
  - seq_alu instantiates it and muxes its product into the result register.

Test Plan (WIDTH=4, outReady=1 unless stated):
- Reset: assert rst_n=0 asynchronously mid-cycle -> immediately outValid=0, inReady=1, result=0000, all flags 0.
- Logic back-to-back: AND 1101,0011 then OR 1101,0011 then XOR 1101,1101 on consecutive cycles -> outputs on 3 consecutive cycles: 0001 (z0), 1111 (z0), 0000 (z1).
- Arithmetic flags:
  - ADD 0111+0001 -> 1000, ovf=1, c=0.
  - ADD 1111+0001 -> 0000, z=1, c=1, ovf=0.
  - SUB 0011-0101 -> 1110, c=1, ovf=0.
  - SHL 0011 by 2 -> 1100, c=0.
  - SHR 0011 by 1 -> 0001, c=1.
- Multiply:
  - MUL 0011*0101 -> 1111, ovf=0; outValid exactly 4 cycles after accept; inReady=0 in between.
  - MUL 1111*0011 -> 1101, ovf=1.
- Backpressure: hold outReady=0 for 5 cycles after ADD 0010+0010 -> result 0100 stable, inReady=0, a pending AND is not accepted; raise outReady -> AND accepted that cycle, its result appears the next cycle.
- Reset mid-MUL: start MUL 0011*0101, drop rst_n after 2 cycles -> outValid=0; after release, no result is ever emitted and inReady=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, controller state
// encoding and the flag bundle carried alongside each result.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per cycle.
// done/product are combinational during the final iteration so the caller can capture on that edge.
module alu_shift_add_mul #(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic                 busy_reg;
    logic [CNTW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_next;

    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    assign done    = busy_reg && (cnt_reg == CNTW'(WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with valid/ready on both sides and a single result register.
// Single-cycle ops load the result on accept; MUL runs in the iterative sub-unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] result,
    output logic             zeroFlag,
    output logic             carryFlag,
    output logic             overflowFlag,
    output logic             outValid,
    input  logic             outReady
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    flags_t               flags_reg, flags_next;
    logic                 out_valid_reg, out_valid_next;

    logic                 accept, accept_mul, load_alu;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH:0]       sum_ext, diff_ext, shl_ext, shr_ext;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry, alu_ovf;

    assign inReady    = (state_reg == ST_IDLE) && (!out_valid_reg || outReady);
    assign accept     = inValid && inReady;
    assign accept_mul = accept && (opcode == OP_MUL);
    assign load_alu   = accept && (opcode != OP_MUL);

    alu_shift_add_mul #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_mul),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // Extra top/bottom bit in the shift vectors captures the last bit shifted out.
    assign shamt    = B[SHW-1:0];
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};
    assign shl_ext  = {1'b0, A} << shamt;
    assign shr_ext  = {A, 1'b0} >> shamt;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
                alu_ovf   = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
            end
            OP_SHL: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res   = shr_ext[WIDTH:1];
                alu_carry = shr_ext[0];
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        result_next    = result_reg;
        flags_next     = flags_reg;
        out_valid_next = out_valid_reg;

        if (out_valid_reg && outReady) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept_mul) begin
                    state_next = ST_MUL_BUSY;
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (mul_done) begin
            result_next         = mul_product[WIDTH-1:0];
            flags_next.carry    = 1'b0;
            flags_next.overflow = |mul_product[2*WIDTH-1:WIDTH];
            flags_next.zero     = (mul_product[WIDTH-1:0] == '0);
            out_valid_next      = 1'b1;
        end else if (load_alu) begin
            result_next         = alu_res;
            flags_next.carry    = alu_carry;
            flags_next.overflow = alu_ovf;
            flags_next.zero     = (alu_res == '0);
            out_valid_next      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            result_reg    <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            result_reg    <= result_next;
            flags_reg     <= flags_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign result       = result_reg;
    assign zeroFlag     = flags_reg.zero;
    assign carryFlag    = flags_reg.carry;
    assign overflowFlag = flags_reg.overflow;
    assign outValid     = out_valid_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=4): stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on every output transfer.
module tb_seq_alu;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic [2:0]   opcode;
    logic         inValid, inReady;
    logic [W-1:0] result;
    logic         zeroFlag, carryFlag, overflowFlag;
    logic         outValid, outReady;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .A            (A),
        .B            (B),
        .opcode       (opcode),
        .inValid      (inValid),
        .inReady      (inReady),
        .result       (result),
        .zeroFlag     (zeroFlag),
        .carryFlag    (carryFlag),
        .overflowFlag (overflowFlag),
        .outValid     (outValid),
        .outReady     (outReady)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: compares every transfer (outValid && outReady) against the queue head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && outValid && outReady) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %b, expected no output", result);
            end else begin
                e = sb.pop_front();
                chk("out_result", 32'(result), 32'(e.res));
                chk("out_flags_zco", 32'({zeroFlag, carryFlag, overflowFlag}), 32'({e.z, e.c, e.o}));
            end
        end
    end

    // Drive one operation; waits (bounded) until accepted, returning after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input exp_t e, output int waits);
        waits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            A = a; B = b; opcode = op; inValid = 1'b1;
            #1;
            if (inReady) begin
                sb.push_back(e);
                @(posedge clk);
                return;
            end
            waits++;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", waits);
    endtask

    task automatic idle();
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic mul_latency(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int w;
        send(a, b, 3'b111, e, w);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            inValid = 1'b0;
            #1;
            if (i < 5) begin
                chk("mul_busy_outValid", 32'(outValid), 32'd0);
                chk("mul_busy_inReady", 32'(inReady), 32'd0);
            end else begin
                chk("mul_done_outValid", 32'(outValid), 32'd1);
            end
        end
    endtask

    initial begin
        int   w;
        logic seen;

        rst_n = 1'b0; A = '0; B = '0; opcode = '0; inValid = 1'b0; outReady = 1'b1;
        #2;
        chk("reset_outValid", 32'(outValid), 32'd0);
        chk("reset_inReady", 32'(inReady), 32'd1);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({zeroFlag, carryFlag, overflowFlag}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Logic ops back-to-back: every send must be accepted without waiting.
        send(4'b1101, 4'b0011, 3'b100, '{res: 4'b0001, z: 1'b0, c: 1'b0, o: 1'b0}, w);
        send(4'b1101, 4'b0011, 3'b101, '{res: 4'b1111, z: 1'b0, c: 1'b0, o: 1'b0}, w);
        chk("b2b_or_waits", 32'(w), 32'd0);
        send(4'b1101, 4'b1101, 3'b110, '{res: 4'b0000, z: 1'b1, c: 1'b0, o: 1'b0}, w);
        chk("b2b_xor_waits", 32'(w), 32'd0);

        // Arithmetic and shift flags.
        send(4'b0111, 4'b0001, 3'b000, '{res: 4'b1000, z: 1'b0, c: 1'b0, o: 1'b1}, w);
        send(4'b1111, 4'b0001, 3'b000, '{res: 4'b0000, z: 1'b1, c: 1'b1, o: 1'b0}, w);
        send(4'b0011, 4'b0101, 3'b001, '{res: 4'b1110, z: 1'b0, c: 1'b1, o: 1'b0}, w);
        send(4'b0011, 4'b0010, 3'b010, '{res: 4'b1100, z: 1'b0, c: 1'b0, o: 1'b0}, w);
        send(4'b0011, 4'b0001, 3'b011, '{res: 4'b0001, z: 1'b0, c: 1'b1, o: 1'b0}, w);
        idle();

        // Multiply: 3*5=15, 15*3=45 (truncated to 1101 with overflow).
        mul_latency(4'b0011, 4'b0101, '{res: 4'b1111, z: 1'b0, c: 1'b0, o: 1'b0});
        mul_latency(4'b1111, 4'b0011, '{res: 4'b1101, z: 1'b0, c: 1'b0, o: 1'b1});
        idle();

        // Backpressure: ADD result held while outReady=0, pending AND stays out.
        @(negedge clk);
        outReady = 1'b0;
        send(4'b0010, 4'b0010, 3'b000, '{res: 4'b0100, z: 1'b0, c: 1'b0, o: 1'b0}, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = 4'b1100; B = 4'b1010; opcode = 3'b100; inValid = 1'b1;
            #1;
            chk("hold_result", 32'(result), 32'b0100);
            chk("hold_inReady", 32'(inReady), 32'd0);
            chk("hold_outValid", 32'(outValid), 32'd1);
        end
        @(negedge clk);
        outReady = 1'b1;
        #1;
        chk("release_inReady", 32'(inReady), 32'd1);
        sb.push_back('{res: 4'b1000, z: 1'b0, c: 1'b0, o: 1'b0});
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        #1;
        chk("release_and_outValid", 32'(outValid), 32'd1);
        chk("release_and_result", 32'(result), 32'b1000);
        idle();

        // Reset mid-MUL: the pending product must never appear.
        send(4'b0011, 4'b0101, 3'b111, '{res: 4'b1111, z: 1'b0, c: 1'b0, o: 1'b0}, w);
        @(negedge clk);
        inValid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midmul_rst_outValid", 32'(outValid), 32'd0);
        chk("midmul_rst_inReady", 32'(inReady), 32'd1);
        chk("midmul_rst_result", 32'(result), 32'd0);
        chk("midmul_rst_flags", 32'({zeroFlag, carryFlag, overflowFlag}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (outValid) seen = 1'b1;
        end
        chk("midmul_no_output", 32'(seen), 32'd0);
        chk("midmul_inReady", 32'(inReady), 32'd1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
